// File: rtl/pipeline_ctrl_n.sv
// Pipeline hazard/exception controller: stall vector from per-stage requests,
// registered multi-cycle flush with PC redirect, and a stall watchdog.
module pipeline_ctrl_n #(
    parameter int          STAGES       = 6,
    parameter int          EXC_W        = 32,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          CNT_W        = 8,
    parameter int          TIMEOUT      = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [EXC_W-1:0]  exception_i,
    input  logic              eret_i,
    input  logic [31:0]       cp0_epc_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              stall_timeout_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state;
    logic [FC_W-1:0]   flush_cnt;
    logic [STAGES-1:0] stall_mask;
    logic              stall_active;
    logic [CNT_W-1:0]  cnt_next;
    logic              unused_pc_stall_req;

    // The PC stage never raises its own stall; its request bit is a don't-care.
    assign unused_pc_stall_req = stallreq_i[0];

    // OR of per-requester prefixes equals the prefix of the highest requester.
    always_comb begin
        stall_mask = '0;
        for (int s = 1; s < STAGES; s++) begin
            if (stallreq_i[s]) begin
                for (int j = 0; j < STAGES; j++) begin
                    if (j <= s) stall_mask[j] = 1'b1;
                end
            end
        end
    end

    assign stall_o      = (state == RUN) ? stall_mask : '0;
    assign stall_active = |stall_o;

    always_comb begin
        cnt_next = '0;
        if (stall_active) begin
            if (&stall_cnt_o) cnt_next = stall_cnt_o;
            else              cnt_next = stall_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flush_o   <= 1'b0;
            new_pc_o  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (|exception_i) begin
                        state     <= FLUSH;
                        flush_o   <= 1'b1;
                        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                        new_pc_o  <= eret_i ? cp0_epc_i : EXC_VECTOR;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= RUN;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= RUN;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog is sticky: once the count hits the limit only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o     <= '0;
            stall_timeout_o <= 1'b0;
        end else begin
            stall_cnt_o <= cnt_next;
            if (cnt_next >= CNT_W'(TIMEOUT)) stall_timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl_n.sv
// Directed bench for pipeline_ctrl_n: two instances (1- and 3-cycle flush)
// driven by the same stimulus, checked against hand-computed values.
module tb_pipeline_ctrl_n;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq_i;
    logic [31:0] exception_i;
    logic        eret_i;
    logic [31:0] cp0_epc_i;

    logic [5:0]  stall1, stall3;
    logic        flush1, flush3;
    logic [31:0] pc1, pc3;
    logic [7:0]  cnt1, cnt3;
    logic        to1, to3;

    int errors = 0;
    int checks = 0;

    pipeline_ctrl_n #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .exception_i(exception_i),
        .eret_i(eret_i), .cp0_epc_i(cp0_epc_i), .stall_o(stall1), .flush_o(flush1),
        .new_pc_o(pc1), .stall_cnt_o(cnt1), .stall_timeout_o(to1)
    );

    pipeline_ctrl_n #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .exception_i(exception_i),
        .eret_i(eret_i), .cp0_epc_i(cp0_epc_i), .stall_o(stall3), .flush_o(flush3),
        .new_pc_o(pc3), .stall_cnt_o(cnt3), .stall_timeout_o(to3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // New inputs land just after an edge; outputs are sampled once they settle.
    task automatic applyStimulus(input logic [5:0] req, input logic [31:0] exc,
                                 input logic eret, input logic [31:0] epc);
        @(posedge clk);
        #1;
        stallreq_i  = req;
        exception_i = exc;
        eret_i      = eret;
        cp0_epc_i   = epc;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        rst         = 1'b0;
        stallreq_i  = '0;
        exception_i = '0;
        eret_i      = 1'b0;
        cp0_epc_i   = '0;
        #3;
        checkOutput("reset_stall", 32'(stall1), 32'h0);
        checkOutput("reset_flush", 32'(flush1), 32'h0);
        checkOutput("reset_pc", pc1, 32'h0);
        checkOutput("reset_cnt", 32'(cnt1), 32'h0);
        checkOutput("reset_timeout", 32'(to1), 32'h0);
        #14;
        rst = 1'b1;

        // Priority: highest requester wins
        applyStimulus(6'b001000, 0, 1'b0, 0);
        checkOutput("t1_stall_a", 32'(stall1), 32'h0F);
        checkOutput("t1_flush_a", 32'(flush1), 32'h0);
        applyStimulus(6'b001100, 0, 1'b0, 0);
        checkOutput("t1_stall_b", 32'(stall1), 32'h0F);
        applyStimulus(6'b000100, 0, 1'b0, 0);
        checkOutput("t1_stall_c", 32'(stall1), 32'h07);
        checkOutput("t1_flush_c", 32'(flush1), 32'h0);
        applyStimulus(6'b000001, 0, 1'b0, 0);
        checkOutput("t1_pc_bit_ignored", 32'(stall1), 32'h0);
        checkOutput("t1_cnt_three", 32'(cnt1), 32'd3);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t1_cnt_clear", 32'(cnt1), 32'd0);

        // Ordinary exception, 1- and 3-cycle flush
        applyStimulus(6'b000000, 32'h1, 1'b0, 32'h0000_5555);
        checkOutput("t2_no_comb_flush", 32'(flush1), 32'h0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t2_flush1_on", 32'(flush1), 32'h1);
        checkOutput("t2_pc1", pc1, 32'h20);
        checkOutput("t2_flush3_on", 32'(flush3), 32'h1);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t2_flush1_off", 32'(flush1), 32'h0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t2_flush3_third", 32'(flush3), 32'h1);
        checkOutput("t2_pc3", pc3, 32'h20);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t2_flush3_off", 32'(flush3), 32'h0);

        // ERET with 3-cycle flush; stall and second exception ignored during flush
        applyStimulus(6'b000000, 32'h4, 1'b1, 32'h0000_1040);
        checkOutput("t3_no_comb_flush", 32'(flush3), 32'h0);
        applyStimulus(6'b001000, 0, 1'b0, 32'h0000_7777);
        checkOutput("t3_flush_1", 32'(flush3), 32'h1);
        checkOutput("t3_pc_1", pc3, 32'h1040);
        checkOutput("t3_stall_forced0", 32'(stall3), 32'h0);
        applyStimulus(6'b001000, 32'h5, 1'b0, 32'h0000_7777);
        checkOutput("t3_flush_2", 32'(flush3), 32'h1);
        checkOutput("t3_pc_2", pc3, 32'h1040);
        checkOutput("t3_stall_forced0_2", 32'(stall3), 32'h0);
        checkOutput("t3_b2b_run_stall1", 32'(stall1), 32'h0F);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t3_flush_3", 32'(flush3), 32'h1);
        checkOutput("t3_pc_3", pc3, 32'h1040);
        checkOutput("t3_b2b_flush1", 32'(flush1), 32'h1);
        checkOutput("t3_b2b_pc1", pc1, 32'h20);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t3_flush_end", 32'(flush3), 32'h0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t3_second_exc_ignored", 32'(flush3), 32'h0);

        // Exception and stall request in the same cycle
        applyStimulus(6'b001000, 32'h1, 1'b0, 0);
        checkOutput("t4_stall_same_cycle", 32'(stall1), 32'h0F);
        checkOutput("t4_no_flush_yet", 32'(flush1), 32'h0);
        applyStimulus(6'b001000, 0, 1'b0, 0);
        checkOutput("t4_flush_next", 32'(flush1), 32'h1);
        checkOutput("t4_stall_zero", 32'(stall1), 32'h0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t4_flush3_done", 32'(flush3), 32'h0);

        // Long stall: watchdog at 200, count to 250, then release
        for (int i = 1; i <= 250; i++) begin
            applyStimulus(6'b000100, 0, 1'b0, 0);
            if (i == 1)   checkOutput("t5_cnt_start", 32'(cnt1), 32'd0);
            if (i == 200) begin
                checkOutput("t5_cnt_199", 32'(cnt1), 32'd199);
                checkOutput("t5_to_not_yet", 32'(to1), 32'h0);
            end
            if (i == 201) begin
                checkOutput("t5_cnt_200", 32'(cnt1), 32'd200);
                checkOutput("t5_to_set", 32'(to1), 32'h1);
            end
        end
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t5_cnt_250", 32'(cnt1), 32'd250);
        checkOutput("t5_cnt3_250", 32'(cnt3), 32'd250);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t5_cnt_dropped", 32'(cnt1), 32'd0);
        checkOutput("t5_to_sticky", 32'(to1), 32'h1);
        checkOutput("t5_to3_sticky", 32'(to3), 32'h1);

        // Asynchronous reset in the 2nd cycle of a 3-cycle flush
        applyStimulus(6'b000000, 32'h1, 1'b0, 0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t6_flush_cycle1", 32'(flush3), 32'h1);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t6_flush_cycle2", 32'(flush3), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_flush", 32'(flush3), 32'h0);
        checkOutput("t6_rst_stall", 32'(stall3), 32'h0);
        checkOutput("t6_rst_pc", pc3, 32'h0);
        checkOutput("t6_rst_cnt", 32'(cnt3), 32'h0);
        checkOutput("t6_rst_timeout", 32'(to3), 32'h0);
        #6;
        rst = 1'b1;
        applyStimulus(6'b001000, 0, 1'b0, 0);
        checkOutput("t6_run_stall", 32'(stall3), 32'h0F);
        checkOutput("t6_no_residual", 32'(flush3), 32'h0);
        applyStimulus(6'b000000, 0, 1'b0, 0);
        checkOutput("t6_still_run", 32'(flush3), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
